// File: rtl/fir_filter_param.sv
// fir_filter_param: parametrised pipelined direct-form FIR with a double-buffered coefficient bank.
// Round-half-up output scaling; define FIR_SAT_EN to saturate the output instead of wrapping it.
module fir_filter_param #(
  parameter int TAPS   = 7,
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 13
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic [COEF_W-1:0]        coef_wdata,
  input  logic                     coef_commit,
  output logic                     out_valid,
  output logic [OUT_W-1:0]         out_data
);

  localparam int AW     = $clog2(TAPS);
  localparam int LEVELS = $clog2(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + LEVELS;
  localparam int LAT    = 3 + LEVELS;

  localparam logic signed [ACC_W:0] RND =
    {{(ACC_W-SHIFT+1){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};

  // Number of operands present at a given adder-tree level (level 0 = products).
  function automatic int node_count(input int lvl_idx);
    int n;
    n = TAPS;
    for (int k = 0; k < lvl_idx; k++) n = (n + 1) / 2;
    return n;
  endfunction

  // Stream handshake: in_valid and out_valid are single-cycle strobes with no ready;
  // every cycle with in_valid=1 is accepted and produces exactly one out_valid pulse.

  logic signed [DATA_W-1:0] dly [TAPS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) dly[i] <= '0;
    end else if (in_valid) begin
      dly[0] <= $signed(in_data);
      for (int i = 1; i < TAPS; i++) dly[i] <= dly[i-1];
    end
  end

  logic signed [COEF_W-1:0] shadow      [TAPS];
  logic signed [COEF_W-1:0] shadow_next [TAPS];
  logic signed [COEF_W-1:0] active      [TAPS];
  logic                     addr_ok;

  assign addr_ok = {1'b0, coef_addr} < (AW+1)'(TAPS);

  // A write in the same cycle as a commit lands in the committed set via shadow_next.
  always_comb begin
    for (int i = 0; i < TAPS; i++) begin
      shadow_next[i] = shadow[i];
      if (coef_we && addr_ok && (coef_addr == AW'(i)))
        shadow_next[i] = $signed(coef_wdata);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < TAPS; i++) shadow[i] <= shadow_next[i];
      if (coef_commit) begin
        for (int i = 0; i < TAPS; i++) active[i] <= shadow_next[i];
      end
    end
  end

  // Level 0 holds the registered products; each later level adds pairs and grows by one bit.
  genvar gl, gn;
  generate
    for (gl = 0; gl <= LEVELS; gl++) begin : lvl
      localparam int N = node_count(gl);
      localparam int W = PROD_W + gl;
      logic signed [W-1:0] node [N];

      if (gl == 0) begin : g_mul
        for (gn = 0; gn < N; gn++) begin : g_tap
          always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) node[gn] <= '0;
            else        node[gn] <= PROD_W'(dly[gn]) * PROD_W'(active[gn]);
          end
        end
      end else begin : g_add
        localparam int NP = node_count(gl - 1);
        for (gn = 0; gn < N; gn++) begin : g_node
          if (2*gn + 1 < NP) begin : g_pair
            always_ff @(posedge clk or negedge rst_n) begin
              if (!rst_n) node[gn] <= '0;
              else        node[gn] <= W'(lvl[gl-1].node[2*gn]) + W'(lvl[gl-1].node[2*gn+1]);
            end
          end else begin : g_pass
            always_ff @(posedge clk or negedge rst_n) begin
              if (!rst_n) node[gn] <= '0;
              else        node[gn] <= W'(lvl[gl-1].node[2*gn]);
            end
          end
        end
      end
    end
  endgenerate

  logic [LAT-2:0] vpipe;
  logic           acc_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vpipe <= '0;
    else        vpipe <= {vpipe[LAT-3:0], in_valid};
  end

  assign acc_valid = vpipe[LAT-2];

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W:0]   rnd_sum;
  logic signed [ACC_W:0]   scaled;
  logic        [OUT_W-1:0] out_next;

  assign acc     = lvl[LEVELS].node[0];
  assign rnd_sum = (ACC_W+1)'(acc) + RND;
  assign scaled  = rnd_sum >>> SHIFT;

`ifdef FIR_SAT_EN
  localparam logic signed [ACC_W:0] MAX_V = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] MIN_V = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  always_comb begin
    out_next = OUT_W'(scaled);
    if (scaled > MAX_V)      out_next = {1'b0, {(OUT_W-1){1'b1}}};
    else if (scaled < MIN_V) out_next = {1'b1, {(OUT_W-1){1'b0}}};
  end
`else
  assign out_next = OUT_W'(scaled);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= acc_valid;
      if (acc_valid) out_data <= out_next;
    end
  end

endmodule

// File: tb/tb_fir_filter_param.sv
// Directed bench for fir_filter_param: table-driven vector sets plus hand-written
// sequences for gaps, shadow/commit behaviour and asynchronous reset mid-stream.
module tb_fir_filter_param;

  localparam int TAPS = 7;
  localparam int LAT  = 6;
  localparam int NV   = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        coef_we = 1'b0;
  logic [2:0]  coef_addr = '0;
  logic [15:0] coef_wdata = '0;
  logic        coef_commit = 1'b0;
  logic        out_valid;
  logic [15:0] out_data;

  fir_filter_param #(.TAPS(7), .DATA_W(16), .COEF_W(16), .OUT_W(16), .SHIFT(13)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .coef_commit(coef_commit), .out_valid(out_valid), .out_data(out_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_q[$];
  int          exp_c[$];
  bit          sb_en = 1'b1;
  bit          hold_chk = 1'b0;
  logic [15:0] hold_val = '0;
  string       tag = "init";

  typedef struct {
    logic [15:0] coef [7];
    logic [15:0] din  [7];
    logic [15:0] dout [7];
  } vec_t;

  vec_t        vecs [NV];
  logic [15:0] spec_c [7];
  logic [15:0] new_c  [7];
  logic [15:0] imp    [7];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Scoreboard: every out_valid pulse must match the head of the expected queue in value and cycle.
  always @(negedge clk) begin
    logic [15:0] e;
    int          c;
    if (rst_n && sb_en) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL %s_spurious_out got=%h exp=none", tag, out_data);
        end else begin
          e = exp_q.pop_front();
          c = exp_c.pop_front();
          check({tag, "_out_data"}, {16'h0, out_data}, {16'h0, e});
          check({tag, "_out_cycle"}, cyc, c);
          hold_val = e;
        end
      end else if (hold_chk) begin
        check({tag, "_out_hold"}, {16'h0, out_data}, {16'h0, hold_val});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] x, input bit expect_out, input logic [15:0] e);
    in_valid = 1'b1;
    in_data  = x;
    if (expect_out) begin
      exp_q.push_back(e);
      exp_c.push_back(cyc + LAT);
    end
    step();
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic load(input logic [15:0] c [7]);
    for (int i = 0; i < TAPS; i++) begin
      coef_we    = 1'b1;
      coef_addr  = 3'(i);
      coef_wdata = c[i];
      step();
    end
    coef_we     = 1'b0;
    coef_commit = 1'b1;
    step();
    coef_commit = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    exp_c.delete();
    hold_val = '0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && exp_q.size() > 0; k++) step();
    check({tag, "_drain_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    spec_c = '{16'h0000, 16'h04D8, 16'hE747, 16'h2666, 16'hE747, 16'h04D8, 16'h0000};
    new_c  = '{16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500, 16'h0600, 16'h0700};
    imp    = '{16'h2000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};

    vecs[0].coef = spec_c;
    vecs[0].din  = imp;
    vecs[0].dout = spec_c;
    // Step into flat taps: running sum of 1024 per sample.
    vecs[1].coef = '{16'h0400, 16'h0400, 16'h0400, 16'h0400, 16'h0400, 16'h0400, 16'h0400};
    vecs[1].din  = '{16'h2000, 16'h2000, 16'h2000, 16'h2000, 16'h2000, 16'h2000, 16'h2000};
    vecs[1].dout = '{16'h0400, 16'h0800, 16'h0C00, 16'h1000, 16'h1400, 16'h1800, 16'h1C00};
    // Single unit tap exposes the round-half-up boundaries.
    vecs[2].coef = '{16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[2].din  = '{16'h1000, 16'h0FFF, 16'hF000, 16'hEFFF, 16'h3000, 16'h2FFF, 16'h7FFF};
    vecs[2].dout = '{16'h0001, 16'h0000, 16'h0000, 16'hFFFF, 16'h0002, 16'h0001, 16'h0004};
    vecs[3].coef = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    vecs[3].din  = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    vecs[4].coef = vecs[3].coef;
    vecs[4].din  = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000};
`ifdef FIR_SAT_EN
    vecs[3].dout = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    vecs[4].dout = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000};
`else
    vecs[3].dout = '{16'hFFF8, 16'hFFF0, 16'hFFE8, 16'hFFE0, 16'hFFD8, 16'hFFD0, 16'hFFC8};
    vecs[4].dout = '{16'h0004, 16'h0008, 16'h000C, 16'h0010, 16'h0014, 16'h0018, 16'h001C};
`endif

    tag = "reset";
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      check("reset_out_valid", {31'h0, out_valid}, 0);
      check("reset_out_data", {16'h0, out_data}, 0);
    end

    for (int v = 0; v < NV; v++) begin
      tag = $sformatf("vec%0d", v);
      do_reset();
      load(vecs[v].coef);
      for (int s = 0; s < TAPS; s++) drive(vecs[v].din[s], 1'b1, vecs[v].dout[s]);
      drain();
    end

    tag = "gapped";
    do_reset();
    load(spec_c);
    hold_chk = 1'b1;
    for (int s = 0; s < TAPS; s++) begin
      drive(imp[s], 1'b1, spec_c[s]);
      step();
      step();
    end
    drain();
    hold_chk = 1'b0;

    tag = "shadow";
    do_reset();
    load(spec_c);
    for (int s = 0; s < TAPS; s++) begin
      coef_we    = 1'b1;
      coef_addr  = 3'(s);
      coef_wdata = new_c[s];
      drive(imp[s], 1'b1, spec_c[s]);
    end
    coef_we = 1'b0;
    drain();
    coef_commit = 1'b1;
    step();
    coef_commit = 1'b0;
    tag = "commit";
    for (int s = 0; s < TAPS; s++) drive(imp[s], 1'b1, new_c[s]);
    drain();

    tag = "bypass";
    coef_we    = 1'b1;
    coef_addr  = 3'd7;
    coef_wdata = 16'h7FFF;
    step();
    coef_addr   = 3'd3;
    coef_wdata  = 16'h1234;
    coef_commit = 1'b1;
    step();
    coef_we     = 1'b0;
    coef_commit = 1'b0;
    for (int s = 0; s < TAPS; s++)
      drive(imp[s], 1'b1, (s == 3) ? 16'h1234 : new_c[s]);
    drain();

    tag = "midrst";
    do_reset();
    load(spec_c);
    sb_en = 1'b0;
    for (int s = 0; s < TAPS; s++) drive(imp[s], 1'b0, 16'h0);
    check("midrst_pre_valid", {31'h0, out_valid}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'h0, out_valid}, 0);
    check("midrst_out_data", {16'h0, out_data}, 0);
    exp_q.delete();
    exp_c.delete();
    hold_val = '0;
    sb_en = 1'b1;
    repeat (2) step();
    rst_n = 1'b1;
    hold_chk = 1'b1;
    repeat (15) step();
    tag = "postrst";
    for (int s = 0; s < TAPS; s++) drive(imp[s], 1'b1, 16'h0000);
    drain();
    hold_chk = 1'b0;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
